// File: rtl/fp_mul_exp_pipe_if.sv
// Handshake, operand, result and sticky-status bundle for the exponent combine stage.
// master drives operations and out_ready; slave is the pipeline stage itself.
interface fp_mul_exp_pipe_if #(
  parameter int unsigned EXP_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic             sign1;
  logic             sign2;
  logic [EXP_W-1:0] exp1;
  logic [EXP_W-1:0] exp2;
  logic             carry;
  logic             out_valid;
  logic             out_ready;
  logic             sign_out;
  logic [EXP_W-1:0] sum_exp;
  logic             ovf;
  logic             unf;
  logic             zero_out;
  logic             clr_flags;
  logic             ovf_sticky;
  logic             unf_sticky;

  modport master (
    output in_valid, sign1, sign2, exp1, exp2, carry, out_ready, clr_flags,
    input  in_ready, out_valid, sign_out, sum_exp, ovf, unf, zero_out, ovf_sticky, unf_sticky
  );

  modport slave (
    input  in_valid, sign1, sign2, exp1, exp2, carry, out_ready, clr_flags,
    output in_ready, out_valid, sign_out, sum_exp, ovf, unf, zero_out, ovf_sticky, unf_sticky
  );
endinterface

// File: rtl/fp_mul_exp_pipe.sv
// Sign/exponent combine stage of the FPU multiplier: bias removal, range classification,
// and a valid/ready register with a one-entry skid buffer plus sticky ovf/unf status.
module fp_mul_exp_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned BIAS  = 2**(EXP_W-1)-1,
  parameter int unsigned SAT   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  fp_mul_exp_pipe_if.slave io_bus
);

  localparam int unsigned SumW = EXP_W + 2;
  localparam logic signed [SumW-1:0] BiasS  = SumW'(BIAS);
  localparam logic signed [SumW-1:0] OvfLim = SumW'((2**EXP_W) - 1);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic             ovf;
    logic             unf;
    logic             zero;
  } res_t;

  logic signed [SumW-1:0] w_sum;
  res_t                   w_res;

  res_t r_m;
  res_t r_s;
  logic r_m_valid;
  logic r_s_valid;
  logic r_ovf_sticky;
  logic r_unf_sticky;

  res_t w_m_d;
  res_t w_s_d;
  logic w_m_valid_d;
  logic w_s_valid_d;
  logic w_ovf_sticky_d;
  logic w_unf_sticky_d;

  logic w_accept;
  logic w_xfer;
  logic w_m_free;

  // Full-width signed sum so out-of-range results classify correctly before any truncation.
  always_comb begin
    w_sum = $signed({2'b00, io_bus.exp1}) + $signed({2'b00, io_bus.exp2})
          + $signed({{(SumW-1){1'b0}}, io_bus.carry}) - BiasS;
  end

  always_comb begin
    w_res      = '0;
    w_res.sign = io_bus.sign1 ^ io_bus.sign2;
    if ((io_bus.exp1 == '0) || (io_bus.exp2 == '0)) begin
      w_res.zero = 1'b1;
    end else begin
      w_res.ovf = (w_sum >= OvfLim);
      w_res.unf = w_sum[SumW-1] || (w_sum == '0);
      w_res.exp = w_sum[EXP_W-1:0];
      if (SAT != 0) begin
        if (w_res.ovf) begin
          w_res.exp = '1;
        end else if (w_res.unf) begin
          w_res.exp = '0;
        end
      end
    end
  end

  assign w_accept = io_bus.in_valid && !r_s_valid;
  assign w_xfer   = r_m_valid && io_bus.out_ready;
  assign w_m_free = !r_m_valid || io_bus.out_ready;

  // in_ready comes only from r_s_valid, so a skid entry never coexists with an accept.
  always_comb begin
    w_m_d       = r_m;
    w_s_d       = r_s;
    w_m_valid_d = r_m_valid;
    w_s_valid_d = r_s_valid;
    if (w_m_free) begin
      if (r_s_valid) begin
        w_m_d       = r_s;
        w_m_valid_d = 1'b1;
        w_s_valid_d = 1'b0;
      end else begin
        w_m_valid_d = w_accept;
        if (w_accept) begin
          w_m_d = w_res;
        end
      end
    end else if (w_accept) begin
      w_s_d       = w_res;
      w_s_valid_d = 1'b1;
    end
  end

  // A set on the transferring result wins over a same-edge clear.
  always_comb begin
    w_ovf_sticky_d = (io_bus.clr_flags ? 1'b0 : r_ovf_sticky) | (w_xfer & r_m.ovf);
    w_unf_sticky_d = (io_bus.clr_flags ? 1'b0 : r_unf_sticky) | (w_xfer & r_m.unf);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m          <= '0;
      r_s          <= '0;
      r_m_valid    <= 1'b0;
      r_s_valid    <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_unf_sticky <= 1'b0;
    end else begin
      r_m          <= w_m_d;
      r_s          <= w_s_d;
      r_m_valid    <= w_m_valid_d;
      r_s_valid    <= w_s_valid_d;
      r_ovf_sticky <= w_ovf_sticky_d;
      r_unf_sticky <= w_unf_sticky_d;
    end
  end

  assign io_bus.in_ready   = !r_s_valid;
  assign io_bus.out_valid  = r_m_valid;
  assign io_bus.sign_out   = r_m.sign;
  assign io_bus.sum_exp    = r_m.exp;
  assign io_bus.ovf        = r_m.ovf;
  assign io_bus.unf        = r_m.unf;
  assign io_bus.zero_out   = r_m.zero;
  assign io_bus.ovf_sticky = r_ovf_sticky;
  assign io_bus.unf_sticky = r_unf_sticky;

endmodule
